// File: rtl/mux_capture_pkg.sv
// Shared types and defaults for the mux_capture serial-to-parallel stage.
package mux_capture_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // A handshake transfer happens when both sides agree in the same cycle.
  function automatic logic xfer(input logic vld, input logic rdy);
    return vld & rdy;
  endfunction

endpackage

// File: rtl/mux_capture_shift_in_reg.sv
// Left-shifting serial-in register with synchronous clear; new bits enter at the LSB.
module shift_in_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/mux_capture.sv
// Serial-to-parallel capture of the select-mux output with valid/ready on both sides.
// Optional parity output enabled by defining MUX_CAPTURE_PARITY_EN.
module mux_capture
  import mux_capture_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic             bit_rdy,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic [CNT_W-1:0] bit_cnt
`ifdef MUX_CAPTURE_PARITY_EN
  ,
  output logic             word_par
`endif
);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             fill;
  logic             bit_take;
  logic             word_take;
  logic             last_bit;
  logic             fill_clear;
  logic [WIDTH-1:0] word_nxt;

  assign fill       = (state == FILL);
  // clear wins over a simultaneously offered bit, and only acts while filling.
  assign fill_clear = fill & clear;
  assign bit_take   = xfer(bit_vld, bit_rdy) & ~clear;
  assign word_take  = xfer(word_vld, word_rdy);
  assign last_bit   = (bit_cnt == CNT_W'(WIDTH - 1));
  assign word_nxt   = {shreg[WIDTH-2:0], bit_in};

  shift_in_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .clear (fill_clear),
    .en    (bit_take),
    .din   (bit_in),
    .q     (shreg)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs decoded from the registered state.
  always_comb begin
    state_nxt = state;
    bit_rdy   = 1'b0;
    word_vld  = 1'b0;
    unique case (state)
      FILL: begin
        bit_rdy = 1'b1;
        if (bit_take && last_bit) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        word_vld = 1'b1;
        if (word_take) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Bit counter and output word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      word_out <= '0;
    end else if (fill_clear) begin
      bit_cnt <= '0;
    end else if (bit_take) begin
      if (last_bit) begin
        bit_cnt  <= '0;
        word_out <= word_nxt;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

`ifdef MUX_CAPTURE_PARITY_EN
  // Parity is captured alongside word_out so it stays aligned through HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_par <= 1'b0;
    end else if (bit_take && last_bit && !fill_clear) begin
      word_par <= ^word_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mux_capture.sv
// Directed self-checking bench for mux_capture (WIDTH=8, CNT_W=4).
module tb_mux_capture;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             bit_in;
  logic             bit_vld;
  logic             bit_rdy;
  logic             clear;
  logic [WIDTH-1:0] word_out;
  logic             word_vld;
  logic             word_rdy;
  logic [CNT_W-1:0] bit_cnt;
`ifdef MUX_CAPTURE_PARITY_EN
  logic             word_par;
`endif

  int total = 0;
  int bad   = 0;

  mux_capture #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (bit_in),
    .bit_vld  (bit_vld),
    .bit_rdy  (bit_rdy),
    .clear    (clear),
    .word_out (word_out),
    .word_vld (word_vld),
    .word_rdy (word_rdy),
    .bit_cnt  (bit_cnt)
`ifdef MUX_CAPTURE_PARITY_EN
    ,
    .word_par (word_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in  = b;
    bit_vld = 1'b1;
    tick();
    bit_vld = 1'b0;
  endtask

  // Sends a word MSB first, checking the counter after each accepted bit.
  task automatic send_word(input logic [WIDTH-1:0] w, input string tag);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(w[i]);
      chk({tag, "_cnt"}, 32'(bit_cnt), (i == 0) ? 32'd0 : 32'(WIDTH - i));
      if (i == 1) chk({tag, "_vld_early"}, 32'(word_vld), 32'd0);
    end
  endtask

  task automatic check_word(input logic [WIDTH-1:0] w, input string tag);
    chk({tag, "_vld"}, 32'(word_vld), 32'd1);
    chk({tag, "_rdy"}, 32'(bit_rdy), 32'd0);
    chk({tag, "_word"}, 32'(word_out), 32'(w));
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_vld = 1'b0; clear = 1'b0; word_rdy = 1'b0;
    tick(); tick();
    chk("rst_cnt",  32'(bit_cnt),  32'd0);
    chk("rst_word", 32'(word_out), 32'd0);
    chk("rst_vld",  32'(word_vld), 32'd0);
    chk("rst_rdy",  32'(bit_rdy),  32'd1);
    reset = 1'b0;

    // Basic word with downstream ready: one HOLD cycle, then back to FILL.
    word_rdy = 1'b1;
    send_word(8'hB2, "t1");
    check_word(8'hB2, "t1");
`ifdef MUX_CAPTURE_PARITY_EN
    chk("t1_par", 32'(word_par), 32'd0);
`endif
    tick();
    chk("t1_vld_drop", 32'(word_vld), 32'd0);
    chk("t1_rdy_rise", 32'(bit_rdy),  32'd1);

    // Backpressure: HOLD is stable and upstream bits are not consumed.
    word_rdy = 1'b0;
    send_word(8'hB2, "t2");
    bit_vld = 1'b1; bit_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_word(8'hB2, "t2_hold");
      chk("t2_hold_cnt", 32'(bit_cnt), 32'd0);
    end
    bit_vld = 1'b0; word_rdy = 1'b1;
    tick();
    chk("t2_release_vld", 32'(word_vld), 32'd0);
    chk("t2_release_cnt", 32'(bit_cnt),  32'd0);

    // clear drops the partial word and the bit offered alongside it.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    chk("t3_cnt3", 32'(bit_cnt), 32'd3);
    clear = 1'b1; bit_vld = 1'b1; bit_in = 1'b0;
    tick();
    clear = 1'b0; bit_vld = 1'b0;
    chk("t3_clear_cnt", 32'(bit_cnt), 32'd0);
    send_word(8'hFF, "t3");
    check_word(8'hFF, "t3");
    tick();

    // Reset mid-word returns everything to reset values.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("t4_cnt5", 32'(bit_cnt), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_rst_cnt",  32'(bit_cnt),  32'd0);
    chk("t4_rst_word", 32'(word_out), 32'd0);
    chk("t4_rst_vld",  32'(word_vld), 32'd0);
    chk("t4_rst_rdy",  32'(bit_rdy),  32'd1);
    send_word(8'h5A, "t4");
    check_word(8'h5A, "t4");
    tick();

    // Gapped valid: counter only moves on transfer cycles.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(8'hC3 >> i);
      chk("t5_cnt_xfer", 32'(bit_cnt), (i == 0) ? 32'd0 : 32'(WIDTH - i));
      if (i != 0) begin
        tick(); tick();
        chk("t5_cnt_gap", 32'(bit_cnt), 32'(WIDTH - i));
      end
    end
    check_word(8'hC3, "t5");
    tick();
    chk("t5_done_vld", 32'(word_vld), 32'd0);

`ifdef MUX_CAPTURE_PARITY_EN
    send_word(8'h07, "t6");
    check_word(8'h07, "t6");
    chk("t6_par", 32'(word_par), 32'd1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_capture.md
Name: mux_capture

Overview:
- Serial-to-parallel capture stage directly downstream of the 2:1 select mux.
- Samples the mux's 1-bit output under a valid/ready handshake and assembles WIDTH consecutive bits into a word.
- Presents the word to the next stage with its own valid/ready handshake; stalls upstream while the word is unaccepted.

Parameters:
- WIDTH, 8, number of bits assembled per output word (legal range 2..32).
- CNT_W, 4, width of the bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data, driven by the mux output.
- bit_vld  input  1  bit_in is valid this cycle.
- bit_rdy  output  1  block accepts a bit this cycle. A transfer occurs when bit_vld && bit_rdy.
- clear  input  1  synchronous discard of the partial word.
- word_out  output  WIDTH  assembled word; first-received bit in the MSB.
- word_vld  output  1  word_out is valid.
- word_rdy  input  1  downstream accepts the word. A transfer occurs when word_vld && word_rdy.
- bit_cnt  output  CNT_W  number of bits held in the partial word (0..WIDTH-1).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Reset has priority over every other input.
- Reset values:
  - state = FILL
  - bit_cnt = 0
  - word_out = 0
  - word_vld = 0
  - bit_rdy = 1 (bit_rdy is combinational from state)
  - internal shift register = 0
- States (2, registered):
  - FILL: bit_rdy = 1, word_vld = 0.
  - HOLD: bit_rdy = 0, word_vld = 1.
- FILL, on a bit transfer:
  - shreg <= {shreg[WIDTH-2:0], bit_in}.
  - If bit_cnt == WIDTH-1: word_out <= {shreg[WIDTH-2:0], bit_in}, bit_cnt <= 0, state <= HOLD.
  - Otherwise: bit_cnt <= bit_cnt + 1.
- FILL, no transfer: all state holds.
- HOLD:
  - word_out is stable and word_vld is held until the word transfer.
  - On word transfer: state <= FILL. word_vld drops and bit_rdy rises in the following cycle.
  - There is no same-cycle bypass: at most one word per WIDTH+1 cycles.
- Latency: word_vld rises exactly 1 cycle after the clock edge that accepted the WIDTH-th bit.
- clear:
  - In FILL: bit_cnt <= 0 and shreg <= 0. A bit offered in the same cycle is dropped, even though bit_rdy = 1.
  - In HOLD: ignored; the held word is never discarded by clear.
- Reset mid-word or mid-HOLD: the partial or held word is lost and the block returns to the reset values.
- bit_vld in HOLD: ignored (no transfer, because bit_rdy = 0); upstream must hold its data.
- word_rdy in FILL: ignored.
- bit_cnt never exceeds WIDTH-1; there is no wrap other than the WIDTH-1 -> 0 transition on word completion.

Optional Feature:
- Macro: MUX_CAPTURE_PARITY_EN.
- Defined:
  - Adds output port word_par (1 bit) = even parity (XOR reduction) of the completed word.
  - Registered on the same edge as word_out, stable throughout HOLD.
  - Reset value 0; unaffected by clear.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header:
  - state encodings FILL = 1'b0, HOLD = 1'b1
  - default WIDTH = 8 and CNT_W = 4
  - handshake transfer helper definition (vld && rdy)
- One natural sub-module: shift_in_reg.
  - Parameterised WIDTH, left-shift with serial input, synchronous clear.
- The FSM, counter and output register stay in mux_capture.

Test Plan:
- Reset, then bits 1,0,1,1,0,0,1,0 with bit_vld held 1 and word_rdy = 1 -> word_out = 8'hB2, word_vld high exactly 1 cycle after the 8th bit, then low; bit_rdy low during that cycle.
- Word completes with word_rdy = 0 for 5 cycles while bit_vld = 1 -> word_vld and word_out = 8'hB2 stable, bit_rdy = 0, no bits consumed. word_rdy = 1 -> next word starts from bit_cnt = 0.
- Send 3 bits (bit_cnt = 3), pulse clear alongside a bit, then send 8'hFF -> bit_cnt = 0 after clear; that bit is dropped; word_out = 8'hFF.
- Send 5 bits, assert reset for 1 cycle -> bit_cnt = 0, word_out = 0, word_vld = 0, bit_rdy = 1. Then a full 8'h5A -> word_out = 8'h5A.
- Gapped bit_vld (valid every 3rd cycle), 8'hC3 -> word_out = 8'hC3; bit_cnt increments only on transfer cycles.
- With MUX_CAPTURE_PARITY_EN: words 8'hB2 then 8'h07 -> word_par = 0 then 1. Rebuild without the macro -> compiles with no word_par port.
